// File: rtl/keypad_scan_ctrl.sv
// Column scanner and row debouncer for a 4x4 active-low matrix keypad.
// Accepted presses are presented as a hex code with a valid/ack handshake.
module keypad_scan_ctrl #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [1:0] col_sel,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ack,
    output logic       key_down,
    output logic       overrun
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DEB_W = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CNT - 1);

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_PRESSED,
        ST_RELEASE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_sync1;
    logic [3:0]       r_row_s;
    logic [DIV_W-1:0] r_div_cnt;
    logic             w_tick;
    logic [1:0]       r_col_sel;
    logic [1:0]       w_col_nxt;
    logic [1:0]       r_cand_row;
    logic [1:0]       w_cand_nxt;
    logic [DEB_W-1:0] r_deb_cnt;
    logic [DEB_W-1:0] w_deb_nxt;
    logic             w_row_hit;
    logic [1:0]       w_row_idx;
    logic [3:0]       w_cand_pat;
    logic             w_accept;
    logic [3:0]       w_new_code;
    logic [3:0]       r_key_code;
    logic             r_key_valid;
    logic             r_overrun;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1   <= 4'b1111;
            r_row_s   <= 4'b1111;
            r_div_cnt <= '0;
        end else begin
            r_sync1   <= row_in;
            r_row_s   <= r_sync1;
            r_div_cnt <= (r_div_cnt == DIV_LAST) ? '0 : r_div_cnt + DIV_W'(1);
        end
    end

    assign w_tick     = (r_div_cnt == DIV_LAST);
    assign w_cand_pat = ~(4'b0001 << r_cand_row);
    assign w_new_code = {r_cand_row, 2'b00} + {2'b00, r_col_sel} + 4'd1;

    // Only a single low row is a key; ghost/multi-key patterns read as idle.
    always_comb begin
        w_row_hit = 1'b1;
        w_row_idx = 2'd0;
        case (r_row_s)
            4'b1110: w_row_idx = 2'd0;
            4'b1101: w_row_idx = 2'd1;
            4'b1011: w_row_idx = 2'd2;
            4'b0111: w_row_idx = 2'd3;
            default: w_row_hit = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_col_nxt   = r_col_sel;
        w_cand_nxt  = r_cand_row;
        w_deb_nxt   = r_deb_cnt;
        w_accept    = 1'b0;
        if (w_tick) begin
            case (r_state)
                ST_SCAN: begin
                    if (w_row_hit) begin
                        w_cand_nxt  = w_row_idx;
                        w_deb_nxt   = '0;
                        w_state_nxt = ST_DEBOUNCE;
                    end else begin
                        w_col_nxt = r_col_sel + 2'd1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (r_row_s == w_cand_pat) begin
                        if (r_deb_cnt == DEB_LAST) begin
                            w_accept    = 1'b1;
                            w_state_nxt = ST_PRESSED;
                        end else begin
                            w_deb_nxt = r_deb_cnt + DEB_W'(1);
                        end
                    end else begin
                        w_state_nxt = ST_SCAN;
                        w_col_nxt   = r_col_sel + 2'd1;
                    end
                end
                ST_PRESSED: begin
                    if (r_row_s == 4'b1111) begin
                        w_deb_nxt   = '0;
                        w_state_nxt = ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (r_row_s == 4'b1111) begin
                        if (r_deb_cnt == DEB_LAST) begin
                            w_state_nxt = ST_SCAN;
                            w_col_nxt   = r_col_sel + 2'd1;
                        end else begin
                            w_deb_nxt = r_deb_cnt + DEB_W'(1);
                        end
                    end else begin
                        w_state_nxt = ST_PRESSED;
                    end
                end
                default: w_state_nxt = ST_SCAN;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_SCAN;
            r_col_sel  <= 2'd0;
            r_cand_row <= 2'd0;
            r_deb_cnt  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_col_sel  <= w_col_nxt;
            r_cand_row <= w_cand_nxt;
            r_deb_cnt  <= w_deb_nxt;
        end
    end

    // An ack arriving with a new key absorbs the old one, so no overrun.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_key_code  <= 4'h0;
            r_key_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else if (w_accept) begin
            r_key_code  <= w_new_code;
            r_key_valid <= 1'b1;
            if (r_key_valid && !key_ack) begin
                r_overrun <= 1'b1;
            end else if (r_key_valid && key_ack) begin
                r_overrun <= 1'b0;
            end
        end else if (key_ack && r_key_valid) begin
            r_key_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end
    end

    assign col_out   = ~(4'b0001 << r_col_sel);
    assign col_sel   = r_col_sel;
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign overrun   = r_overrun;
    assign key_down  = (r_state == ST_PRESSED) || (r_state == ST_RELEASE);

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with SCAN_DIV=4, DEBOUNCE_CNT=2:
// a step table for scan/press/release/handshake plus hand-written reset sequences.
module tb_keypad_scan_ctrl;

    localparam int SCAN_DIV     = 4;
    localparam int DEBOUNCE_CNT = 2;

    logic       clock;
    logic       reset;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [1:0] col_sel;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ack;
    logic       key_down;
    logic       overrun;

    int n_checks = 0;
    int n_fail   = 0;

    keypad_scan_ctrl #(
        .SCAN_DIV    (SCAN_DIV),
        .DEBOUNCE_CNT(DEBOUNCE_CNT)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .row_in   (row_in),
        .col_out  (col_out),
        .col_sel  (col_sel),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_ack  (key_ack),
        .key_down (key_down),
        .overrun  (overrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] row;
        logic       ack;
        int         ncyc;
        logic [1:0] col;
        logic [3:0] code;
        logic       valid;
        logic       down;
        logic       ovr;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [3:0] row, input logic ack, input int ncyc,
                       input logic [1:0] col, input logic [3:0] code,
                       input logic valid, input logic down, input logic ovr);
        vec_t v;
        v.row = row; v.ack = ack; v.ncyc = ncyc; v.col = col;
        v.code = code; v.valid = valid; v.down = down; v.ovr = ovr;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [7:0] act,
                       input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic adv(input int n);
        repeat (n) @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        adv(1);
        reset = 1'b0;
    endtask

    function automatic logic [3:0] col_pat(input logic [1:0] c);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << c);
    endfunction

    task automatic chk_all(input string tag, input int idx, input logic [1:0] col,
                           input logic [3:0] code, input logic valid,
                           input logic down, input logic ovr);
        chk({tag, ".col_sel"}, idx, {6'd0, col_sel}, {6'd0, col});
        chk({tag, ".col_out"}, idx, {4'd0, col_out}, {4'd0, col_pat(col)});
        chk({tag, ".key_code"}, idx, {4'd0, key_code}, {4'd0, code});
        chk({tag, ".key_valid"}, idx, {7'd0, key_valid}, {7'd0, valid});
        chk({tag, ".key_down"}, idx, {7'd0, key_down}, {7'd0, down});
        chk({tag, ".overrun"}, idx, {7'd0, overrun}, {7'd0, ovr});
    endtask

    initial begin
        #100000;
        n_checks++;
        n_fail++;
        $display("FAIL timeout: simulation ran past 100000 time units, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "timeout");
    end

    initial begin
        // Each step: drive row/ack, run ncyc edges, then expect col, code, valid, down, overrun.
        // Steps of 4 cycles end just after a tick edge.
        add(4'b1111, 0, 4, 2'd1, 4'h0, 0, 0, 0);
        add(4'b1111, 0, 4, 2'd2, 4'h0, 0, 0, 0);
        add(4'b1101, 0, 4, 2'd2, 4'h0, 0, 0, 0);   // detect col2 row1
        add(4'b1101, 0, 4, 2'd2, 4'h0, 0, 0, 0);
        add(4'b1101, 0, 4, 2'd2, 4'h7, 1, 1, 0);   // accept 7
        add(4'b1101, 0, 4, 2'd2, 4'h7, 1, 1, 0);
        add(4'b1111, 0, 4, 2'd2, 4'h7, 1, 1, 0);   // release starts
        add(4'b1111, 0, 4, 2'd2, 4'h7, 1, 1, 0);
        add(4'b1111, 0, 4, 2'd3, 4'h7, 1, 0, 0);   // key_down falls, next column
        add(4'b1111, 1, 1, 2'd3, 4'h7, 0, 0, 0);   // ack
        add(4'b1111, 0, 3, 2'd0, 4'h7, 0, 0, 0);
        add(4'b1110, 0, 4, 2'd0, 4'h7, 0, 0, 0);   // bounce: one tick only
        add(4'b1111, 0, 4, 2'd1, 4'h7, 0, 0, 0);
        add(4'b1111, 0, 4, 2'd2, 4'h7, 0, 0, 0);
        add(4'b1111, 0, 4, 2'd3, 4'h7, 0, 0, 0);
        add(4'b0111, 0, 4, 2'd3, 4'h7, 0, 0, 0);   // col3 row3
        add(4'b0111, 0, 4, 2'd3, 4'h7, 0, 0, 0);
        add(4'b0111, 0, 4, 2'd3, 4'h0, 1, 1, 0);   // code wraps to 0
        add(4'b1111, 0, 4, 2'd3, 4'h0, 1, 1, 0);
        add(4'b0111, 0, 4, 2'd3, 4'h0, 1, 1, 0);   // release bounce back to pressed
        add(4'b1111, 0, 4, 2'd3, 4'h0, 1, 1, 0);
        add(4'b1111, 0, 4, 2'd3, 4'h0, 1, 1, 0);
        add(4'b1111, 0, 4, 2'd0, 4'h0, 1, 0, 0);
        add(4'b1111, 1, 1, 2'd0, 4'h0, 0, 0, 0);
        add(4'b1111, 0, 3, 2'd1, 4'h0, 0, 0, 0);
        add(4'b1001, 0, 4, 2'd2, 4'h0, 0, 0, 0);   // ghost pattern
        add(4'b1001, 0, 4, 2'd3, 4'h0, 0, 0, 0);
        add(4'b1001, 0, 4, 2'd0, 4'h0, 0, 0, 0);
        add(4'b1001, 0, 4, 2'd1, 4'h0, 0, 0, 0);
        add(4'b1111, 0, 4, 2'd2, 4'h0, 0, 0, 0);
        add(4'b1111, 0, 4, 2'd3, 4'h0, 0, 0, 0);
        add(4'b1111, 0, 4, 2'd0, 4'h0, 0, 0, 0);
        add(4'b1110, 0, 4, 2'd0, 4'h0, 0, 0, 0);
        add(4'b1110, 0, 4, 2'd0, 4'h0, 0, 0, 0);
        add(4'b1110, 0, 4, 2'd0, 4'h1, 1, 1, 0);   // accept 1, not acked
        add(4'b1111, 0, 4, 2'd0, 4'h1, 1, 1, 0);
        add(4'b1111, 0, 4, 2'd0, 4'h1, 1, 1, 0);
        add(4'b1111, 0, 4, 2'd1, 4'h1, 1, 0, 0);
        add(4'b1011, 0, 4, 2'd1, 4'h1, 1, 0, 0);
        add(4'b1011, 0, 4, 2'd1, 4'h1, 1, 0, 0);
        add(4'b1011, 0, 4, 2'd1, 4'hA, 1, 1, 1);   // overrun
        add(4'b1011, 1, 1, 2'd1, 4'hA, 0, 1, 0);   // ack clears valid and overrun
        add(4'b1111, 0, 3, 2'd1, 4'hA, 0, 1, 0);
        add(4'b1111, 0, 4, 2'd1, 4'hA, 0, 1, 0);
        add(4'b1111, 0, 4, 2'd2, 4'hA, 0, 0, 0);
        add(4'b1111, 1, 1, 2'd2, 4'hA, 0, 0, 0);   // ack with nothing pending
        add(4'b1111, 0, 3, 2'd3, 4'hA, 0, 0, 0);
        add(4'b1110, 0, 4, 2'd3, 4'hA, 0, 0, 0);
        add(4'b1110, 0, 4, 2'd3, 4'hA, 0, 0, 0);
        add(4'b1110, 0, 4, 2'd3, 4'h4, 1, 1, 0);
        add(4'b1111, 0, 4, 2'd3, 4'h4, 1, 1, 0);
        add(4'b1111, 0, 4, 2'd3, 4'h4, 1, 1, 0);
        add(4'b1111, 0, 4, 2'd0, 4'h4, 1, 0, 0);
        add(4'b1110, 0, 4, 2'd0, 4'h4, 1, 0, 0);
        add(4'b1110, 0, 4, 2'd0, 4'h4, 1, 0, 0);
        add(4'b1110, 0, 3, 2'd0, 4'h4, 1, 0, 0);
        add(4'b1110, 1, 1, 2'd0, 4'h1, 1, 1, 0);   // accept with ack on same edge
        add(4'b1110, 0, 4, 2'd0, 4'h1, 1, 1, 0);

        reset   = 1'b1;
        row_in  = 4'b1111;
        key_ack = 1'b0;
        adv(1);
        chk_all("reset", 0, 2'd0, 4'h0, 0, 0, 0);
        reset = 1'b0;

        // Idle rotation, checked every cycle.
        for (int p = 0; p < 20; p++) begin
            chk("idle.col_out", p, {4'd0, col_out}, {4'd0, col_pat(2'((p / 4) % 4))});
            chk("idle.key_valid", p, {7'd0, key_valid}, 8'd0);
            adv(1);
        end

        do_reset();
        for (int i = 0; i < vecs.size(); i++) begin
            row_in  = vecs[i].row;
            key_ack = vecs[i].ack;
            adv(vecs[i].ncyc);
            chk_all("step", i, vecs[i].col, vecs[i].code, vecs[i].valid,
                    vecs[i].down, vecs[i].ovr);
        end

        // Reset coinciding with a tick and an ack while a key is pending and held.
        key_ack = 1'b0;
        adv(3);
        reset   = 1'b1;
        key_ack = 1'b1;
        adv(1);
        chk_all("rst_tick", 0, 2'd0, 4'h0, 0, 0, 0);
        reset   = 1'b0;
        key_ack = 1'b0;
        row_in  = 4'b1111;
        adv(3);
        chk_all("rst_tick", 1, 2'd0, 4'h0, 0, 0, 0);
        adv(1);
        chk_all("rst_tick", 2, 2'd1, 4'h0, 0, 0, 0);

        // Reset mid-debounce with column frozen at 1.
        row_in = 4'b0111;
        adv(4);
        chk_all("rst_deb", 0, 2'd1, 4'h0, 0, 0, 0);
        adv(4);
        chk_all("rst_deb", 1, 2'd1, 4'h0, 0, 0, 0);
        adv(2);
        reset = 1'b1;
        adv(1);
        chk_all("rst_deb", 2, 2'd0, 4'h0, 0, 0, 0);
        reset  = 1'b0;
        row_in = 4'b1111;
        adv(3);
        chk_all("rst_deb", 3, 2'd0, 4'h0, 0, 0, 0);
        adv(1);
        chk_all("rst_deb", 4, 2'd1, 4'h0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_scan_ctrl.md
# keypad_scan_ctrl

Scan controller for the 4x4 matrix keypad. It drives the active-low column strobes and the 2-bit column counter used by the keypad encoder, and synchronizes and debounces the active-low row inputs. Each debounced key press is presented as a 4-bit hex code with a valid/acknowledge handshake. The block sits between the keypad pins and downstream consumers (display or input logic) and replaces free-running column counters.

## Interface
Parameters:
- SCAN_DIV, default 1000: clock cycles per column dwell; must be ≥ 2.
- DEBOUNCE_CNT, default 4: number of consecutive matching samples required to accept a press or a release; must be ≥ 1.

Ports:
- clock  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- row_in  input  4  keypad rows, active low; 4'b1111 means no key. Asynchronous to clock.
- col_out  output  4  column drive, active-low one-hot: col_out = ~(4'b0001 << col_sel).
- col_sel  output  2  current column index (0..3).
- key_code  output  4  last accepted key code.
- key_valid  output  1  high while key_code holds an unacknowledged key.
- key_ack  input  1  consumer acknowledge; sampled on each clock edge.
- key_down  output  1  high while a debounced key is held.
- overrun  output  1  sticky; set when a new key is accepted while key_valid=1 and not acked.

## Operation
- **Row synchronizer.** row_in passes through a 2-flop synchronizer, giving row_s. All row decisions use row_s.
- **Dwell counter.** div_cnt counts 0..SCAN_DIV-1 and wraps. tick = (div_cnt == SCAN_DIV-1). Samples and state transitions happen only on tick, at the end of the dwell.
- **Row decode.** Valid single-low patterns map to row index r: 1110→0, 1101→1, 1011→2, 0111→3. Any other pattern, including ghost/multi-key patterns, counts as "no key".
- **Key code.** key_code = (4*r + col_sel + 1) mod 16, 4 bits. Column 0 gives 1,5,9,D; column 1 gives 2,6,A,E; column 2 gives 3,7,B,F; column 3 gives 4,8,C,0.
- **FSM states:** SCAN, DEBOUNCE, PRESSED, RELEASE.
  - **SCAN.** On tick: if a single row is low, capture cand_row=r, set deb_cnt=0, hold the column, and go to DEBOUNCE. Otherwise advance col_sel by 1 (3 wraps to 0).
  - **DEBOUNCE.** Column is frozen. On tick:
    - row_s equals cand_row's pattern: deb_cnt++. When deb_cnt reaches DEBOUNCE_CNT, accept the key and go to PRESSED.
    - Otherwise: go to SCAN and advance col_sel.
  - **PRESSED.** key_down=1, column frozen. On tick: if row_s==1111, set deb_cnt=0 and go to RELEASE.
  - **RELEASE.** Column frozen, key_down stays 1. On tick:
    - row_s==1111: deb_cnt++. When it reaches DEBOUNCE_CNT, go to SCAN, advance col_sel, and key_down=0.
    - Any other pattern: return to PRESSED with no new key event.
- **Accept.** key_code is loaded from cand_row and col_sel, and key_valid is set to 1.
- **Handshake.**
  - key_ack with key_valid=1 clears key_valid and overrun on the next edge.
  - Accept and key_ack in the same cycle: the new code loads, key_valid stays 1, overrun is not set.
  - Accept while key_valid=1 without key_ack: the new code overwrites key_code and overrun is set to 1.
  - key_ack while key_valid=0 is ignored.

## Timing
- **Reset values:** col_sel=0, col_out=4'b1110, key_code=4'h0, key_valid=0, key_down=0, overrun=0, state=SCAN, div_cnt=0, deb_cnt=0, synchronizer flops=4'b1111.
- **Column advance.** Each column is driven for exactly SCAN_DIV cycles while scanning. col_out and col_sel change on the edge where tick=1.
- **Synchronizer latency.** row_in reaches row_s 2 edges later. row_in must be stable at least 2 cycles before a tick to be seen at that tick.
- **Press latency.** Let the detecting tick be T0, at the end of the dwell. key_valid and key_down rise on the edge at T0 + DEBOUNCE_CNT*SCAN_DIV cycles.
- **Release latency.** key_down falls DEBOUNCE_CNT ticks after the first all-high tick. The next column is driven from the same edge.
- **Reset mid-operation.** Reset has priority over all events, including a tick and key_ack in the same cycle. Any state returns to the reset values on the next edge. A pending key is discarded.
- **div_cnt** never stops; state changes never re-align it.

## Test plan
Use SCAN_DIV=4 and DEBOUNCE_CNT=2 unless noted.
1. **Reset and idle scan.** Assert reset, release, keep row_in=1111. Outputs hold their reset values. col_out sequence is 1110, 1101, 1011, 0111, 1110, 4 cycles each. key_valid stays 0.
2. **Clean press, column 2, row 1.** Hold row_in=1101 while col_sel=2 until accepted. Expect key_code=4'h7, key_valid=1, key_down=1, col_sel frozen at 2. Release to 1111: key_down falls 2 ticks later, then col_sel=3. Pulse key_ack: key_valid→0.
3. **Bounce rejection.** row_in=1110 at col_sel=0 for one tick only, then 1111. key_valid stays 0 and scan resumes at col_sel=1. Also: column 3, row 3 held gives key_code=4'h0.
4. **Ghost pattern.** row_in=1001 held through a full rotation. No DEBOUNCE entry, no key_valid, uninterrupted rotation.
5. **Overrun and simultaneous ack.**
   - Accept 4'h1 with no ack, then accept 4'hA: key_code=A, overrun=1. key_ack clears both key_valid and overrun.
   - Repeat with key_ack in the accept cycle: key_valid=1, overrun=0.
6. **Reset mid-debounce.** Assert reset during DEBOUNCE with row_in=0111. Next edge gives col_out=1110, state SCAN, key_valid=0, key_down=0.
